// File: rtl/padd_pkg.sv
// Shared definitions for the pipelined adder: op encoding, stage count and
// parameter legality helpers.
package padd_pkg;

   localparam logic PADD_OP_ADD = 1'b0;
   localparam logic PADD_OP_SUB = 1'b1;

   localparam int unsigned PADD_MIN_STAGES = 1;
   localparam int unsigned PADD_MAX_STAGES = 16;

   // Number of pipeline stages, one per CHUNK_W slice.
   function automatic int unsigned padd_num_stages(input int unsigned width,
                                                   input int unsigned chunk_w);
      if (chunk_w == 0) begin
         return 0;
      end
      return width / chunk_w;
   endfunction

   // WIDTH must split evenly into chunks and give a supported stage count.
   function automatic bit padd_params_legal(input int unsigned width,
                                            input int unsigned chunk_w);
      int unsigned n;
      if (chunk_w == 0) begin
         return 1'b0;
      end
      n = width / chunk_w;
      return ((width % chunk_w) == 0) && (n >= PADD_MIN_STAGES) && (n <= PADD_MAX_STAGES);
   endfunction

endpackage

// File: rtl/padd_stage.sv
// One pipeline stage of the adder: adds chunk IDX of A and B with the incoming
// carry, merges it into the partial sum and registers the result under a
// valid/ready handshake. Contents hold while the stage is stalled.
module padd_stage #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned CHUNK_W = 4,
   parameter int unsigned SIDE_W  = 4,
   parameter int unsigned IDX     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   // upstream side
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [WIDTH-1:0]  up_sum_i,
   input  logic [WIDTH-1:0]  up_a_i,
   input  logic [WIDTH-1:0]  up_b_i,
   input  logic              up_carry_i,
   input  logic [SIDE_W-1:0] up_side_i,
   // downstream side
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [WIDTH-1:0]  dn_sum_o,
   output logic [WIDTH-1:0]  dn_a_o,
   output logic [WIDTH-1:0]  dn_b_o,
   output logic              dn_carry_o,
   output logic [SIDE_W-1:0] dn_side_o
);

   localparam int unsigned Lsb = IDX * CHUNK_W;

   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [SIDE_W-1:0] side_q, side_d;

   logic [CHUNK_W:0]  chunk_add;
   logic              load;

   // Chunk adder and handshake: stage may take new data when empty or draining.
   always_comb begin
      chunk_add  = {1'b0, up_a_i[Lsb +: CHUNK_W]} + {1'b0, up_b_i[Lsb +: CHUNK_W]}
                 + {{CHUNK_W{1'b0}}, up_carry_i};
      up_ready_o = !valid_q || dn_ready_i;
      load       = up_ready_o && up_valid_i;
   end

   // Next-state: load new operation, drain to empty, or hold while stalled.
   always_comb begin
      valid_d = up_ready_o ? up_valid_i : valid_q;
      sum_d   = sum_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      side_d  = side_q;
      if (load) begin
         sum_d                  = up_sum_i;
         sum_d[Lsb +: CHUNK_W]  = chunk_add[CHUNK_W-1:0];
         a_d                    = up_a_i;
         b_d                    = up_b_i;
         carry_d                = chunk_add[CHUNK_W];
         side_d                 = up_side_i;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         side_q  <= '0;
      end else begin
         valid_q <= valid_d;
         sum_q   <= sum_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         side_q  <= side_d;
      end
   end

   // Register contents drive the next stage directly.
   always_comb begin
      dn_valid_o = valid_q;
      dn_sum_o   = sum_q;
      dn_a_o     = a_q;
      dn_b_o     = b_q;
      dn_carry_o = carry_q;
      dn_side_o  = side_q;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK_W slice per stage, with a
// valid/ready handshake and a sideband tag carried alongside each operation.
// Optional unsigned saturation on the result is enabled by defining PADD_SAT_EN.
module pipelined_adder
   import padd_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned CHUNK_W = 4,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned NumStages = padd_num_stages(WIDTH, CHUNK_W);

`ifdef PADD_SAT_EN
   // The op bit rides with the tag so the last stage knows which clamp applies.
   localparam int unsigned SideW = TAG_W + 1;
`else
   localparam int unsigned SideW = TAG_W;
`endif

   if (!padd_params_legal(WIDTH, CHUNK_W)) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK_W giving 1..16 stages");
   end

   // Index 0 is the input port; index i+1 is the register of stage i.
   logic             vld_s   [NumStages+1];
   logic             rdy_s   [NumStages+1];
   logic [WIDTH-1:0] sum_s   [NumStages+1];
   logic [WIDTH-1:0] a_s     [NumStages+1];
   logic [WIDTH-1:0] b_s     [NumStages+1];
   logic             carry_s [NumStages+1];
   logic [SideW-1:0] side_s  [NumStages+1];

   logic unused_lo_bits;

   // Pipeline entry: B is inverted up front for SUB so every stage just adds.
   always_comb begin
      vld_s[0]   = in_valid;
      sum_s[0]   = '0;
      a_s[0]     = in_a;
      b_s[0]     = (in_op == PADD_OP_SUB) ? ~in_b : in_b;
      carry_s[0] = in_cin;
`ifdef PADD_SAT_EN
      side_s[0]  = {in_op, in_tag};
`else
      side_s[0]  = in_tag;
`endif
      rdy_s[NumStages] = out_ready;
      in_ready         = rdy_s[0];
   end

   for (genvar i = 0; i < NumStages; i++) begin : g_stage
      padd_stage #(
         .WIDTH   (WIDTH),
         .CHUNK_W (CHUNK_W),
         .SIDE_W  (SideW),
         .IDX     (i)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid_i (vld_s[i]),
         .up_ready_o (rdy_s[i]),
         .up_sum_i   (sum_s[i]),
         .up_a_i     (a_s[i]),
         .up_b_i     (b_s[i]),
         .up_carry_i (carry_s[i]),
         .up_side_i  (side_s[i]),
         .dn_valid_o (vld_s[i+1]),
         .dn_ready_i (rdy_s[i+1]),
         .dn_sum_o   (sum_s[i+1]),
         .dn_a_o     (a_s[i+1]),
         .dn_b_o     (b_s[i+1]),
         .dn_carry_o (carry_s[i+1]),
         .dn_side_o  (side_s[i+1])
      );
   end

   // Result flags and optional clamp, all taken from the last stage's register.
   always_comb begin
      out_valid = vld_s[NumStages];
      out_sum   = sum_s[NumStages];
      out_cout  = carry_s[NumStages];
      out_tag   = side_s[NumStages][TAG_W-1:0];
      out_ovf   = (a_s[NumStages][WIDTH-1] == b_s[NumStages][WIDTH-1]) &&
                  (sum_s[NumStages][WIDTH-1] != a_s[NumStages][WIDTH-1]);
`ifdef PADD_SAT_EN
      if ((side_s[NumStages][TAG_W] == PADD_OP_ADD) && carry_s[NumStages]) begin
         out_sum = '1;
      end else if ((side_s[NumStages][TAG_W] == PADD_OP_SUB) && !carry_s[NumStages]) begin
         out_sum = '0;
      end
`endif
   end

   // Only the operand MSBs matter once the last chunk is summed.
   assign unused_lo_bits = ^{a_s[NumStages][WIDTH-1:0], b_s[NumStages][WIDTH-1:0]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK_W=4, TAG_W=4).
// Directed vectors from a table, then random traffic against a reference model
// with a FIFO scoreboard; also covers backpressure and mid-flight reset.
module tb_pipelined_adder;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;
   localparam int unsigned TW = 4;
   localparam int unsigned NS = W / CW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_cin, in_op, out_valid, out_ready;
   logic          out_cout, out_ovf;
   logic [W-1:0]  in_a, in_b, out_sum;
   logic [TW-1:0] in_tag, out_tag;

   always #5 clk = ~clk;

   pipelined_adder #(
      .WIDTH   (W),
      .CHUNK_W (CW),
      .TAG_W   (TW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [W-1:0]  sum;
      logic          cout;
      logic          ovf;
      logic [TW-1:0] tag;
   } res_t;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          cin;
      logic          op;
      logic [TW-1:0] tag;
      logic [W-1:0]  sum;
      logic          cout;
      logic          ovf;
   } vec_t;

   res_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   retired  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Reference: integer arithmetic on the operands, signed range test for overflow.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic op, input logic [TW-1:0] tag);
      res_t         r;
      logic [W-1:0] beff;
      int unsigned  u;
      int           s;
      beff  = op ? ~b : b;
      u     = 32'(a) + 32'(beff) + 32'(cin);
      s     = int'($signed(a)) + int'($signed(beff)) + int'({31'd0, cin});
      r.sum  = u[W-1:0];
      r.cout = (u > 32'hFFFF);
      r.ovf  = (s > 32767) || (s < -32768);
      r.tag  = tag;
`ifdef PADD_SAT_EN
      if (!op && r.cout) r.sum = '1;
      if (op && !r.cout) r.sum = '0;
`endif
      return r;
   endfunction

   // Scoreboard: handshake values are stable at the falling edge before each transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_op, in_tag));
         if (out_valid && out_ready) begin
            res_t e;
            retired++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got result tag 0x%0h expected no result", out_tag);
            end else begin
               e = exp_q.pop_front();
               check("sb_sum",  32'(out_sum),  32'(e.sum));
               check("sb_cout", 32'(out_cout), 32'(e.cout));
               check("sb_ovf",  32'(out_ovf),  32'(e.ovf));
               check("sb_tag",  32'(out_tag),  32'(e.tag));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand(input logic [TW-1:0] tag);
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      in_cin = 1'($urandom);
      in_op  = 1'($urandom);
      in_tag = tag;
   endtask

   // Single op into an empty pipeline; checks latency and result fields.
   task automatic run_vec(input vec_t v, input string name);
      int lat;
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_op = v.op; in_tag = v.tag;
      in_valid = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 20);
      check($sformatf("%s_latency", name), 32'(lat), 32'(NS));
      check($sformatf("%s_sum", name),  32'(out_sum),  32'(v.sum));
      check($sformatf("%s_cout", name), 32'(out_cout), 32'(v.cout));
      check($sformatf("%s_ovf", name),  32'(out_ovf),  32'(v.ovf));
      check($sformatf("%s_tag", name),  32'(out_tag),  32'(v.tag));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      check("drain_in_budget", 32'(n < budget), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   first, last, cnt, acc, start, stale;
      logic ok, pending, have_snap;
      res_t snap;

      vecs[0] = '{a:16'h0000, b:16'h0000, cin:1'b0, op:1'b0, tag:4'h1,
                  sum:16'h0000, cout:1'b0, ovf:1'b0};
      vecs[1] = '{a:16'hFFFF, b:16'h0000, cin:1'b1, op:1'b0, tag:4'h2,
                  sum:16'h0000, cout:1'b1, ovf:1'b0};
      vecs[2] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, op:1'b0, tag:4'h3,
                  sum:16'h8000, cout:1'b0, ovf:1'b1};
`ifdef PADD_SAT_EN
      vecs[3] = '{a:16'h0005, b:16'h0007, cin:1'b1, op:1'b1, tag:4'h4,
                  sum:16'h0000, cout:1'b0, ovf:1'b0};
      vecs[4] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b0, op:1'b0, tag:4'h5,
                  sum:16'hFFFF, cout:1'b1, ovf:1'b0};
`else
      vecs[3] = '{a:16'h0005, b:16'h0007, cin:1'b1, op:1'b1, tag:4'h4,
                  sum:16'hFFFE, cout:1'b0, ovf:1'b0};
      vecs[4] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b0, op:1'b0, tag:4'h5,
                  sum:16'hFFFE, cout:1'b1, ovf:1'b0};
`endif
      vecs[5] = '{a:16'h8000, b:16'h0001, cin:1'b1, op:1'b1, tag:4'h6,
                  sum:16'h7FFF, cout:1'b1, ovf:1'b1};

      // Reset
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0; in_tag = '0;
      repeat (3) tick();
      check("rst_out_valid_during", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_cout",  32'(out_cout),  32'd0);
      check("rst_out_ovf",   32'(out_ovf),   32'd0);
      check("rst_out_tag",   32'(out_tag),   32'd0);

      // Directed table
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
      drain(20);

      // Back-to-back: 8 ops on consecutive cycles, results must be consecutive
      first = -1; last = -1; cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 8) begin
            drive_rand(4'(i));
            in_valid = 1'b1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            if (first < 0) first = i;
            last = i;
            cnt++;
         end
      end
      check("b2b_count", 32'(cnt), 32'd8);
      check("b2b_span",  32'(last - first), 32'd7);
      check("b2b_first", 32'(first), 32'(NS - 1));
      drain(20);

      // Backpressure: out_ready low for 6 cycles with input always offered
      out_ready = 1'b0; acc = 0; pending = 1'b0; have_snap = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (!pending) begin
            drive_rand(4'(i + 8));
            in_valid = 1'b1;
            pending  = 1'b1;
         end
         #1;
         ok = in_ready;
         tick();
         if (ok) begin
            acc++;
            pending = 1'b0;
         end
         if (out_valid) begin
            if (have_snap) begin
               check("bp_stable_sum",  32'(out_sum),  32'(snap.sum));
               check("bp_stable_cout", 32'(out_cout), 32'(snap.cout));
               check("bp_stable_ovf",  32'(out_ovf),  32'(snap.ovf));
               check("bp_stable_tag",  32'(out_tag),  32'(snap.tag));
            end else begin
               snap = '{sum:out_sum, cout:out_cout, ovf:out_ovf, tag:out_tag};
               have_snap = 1'b1;
            end
         end
      end
      check("bp_accepts",   32'(acc), 32'd4);
      check("bp_in_ready",  32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      start = retired;
      drain(20);
      check("bp_drained", 32'(retired - start), 32'd4);

      // Random traffic with random backpressure
      pending = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!pending && ($urandom_range(3) != 0)) begin
            drive_rand(4'($urandom));
            in_valid = 1'b1;
            pending  = 1'b1;
         end
         out_ready = ($urandom_range(2) != 0);
         #1;
         ok = in_valid && in_ready;
         tick();
         if (ok) begin
            pending  = 1'b0;
            in_valid = 1'b0;
         end
      end
      drain(40);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      // Mid-flight reset with 3 ops in the pipe
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_rand(4'(i + 12));
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("mrst_out_valid_before", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid_now", 32'(out_valid), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      start = retired; stale = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) stale++;
      end
      check("mrst_no_stale", 32'(stale), 32'd0);
      check("mrst_no_retire", 32'(retired - start), 32'd0);
      run_vec(vecs[2], "mrst_new");
      drain(20);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
